conv_weight_update: RTL and testbench

- Downstream neighbour of the convolution weight-gradient stage: consumes the gradient tensor that stage writes to memory and applies an SGD step in place, w[i] <= w[i] - lr*g[i].
- Started by the same go/done handshake the FPU stages use. Owns one word-addressed memory request port.
- Arithmetic is signed Q16.16 fixed point with saturation; saturation events are counted for the host.

---
 rtl/conv_weight_update.sv | 173 +++++++++++++++++
 tb/tb_conv_weight_update.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_update.sv
// In-place SGD step over a weight tensor: w[i] <= sat(w[i] - sat(lr*g[i] >> FRAC)).
// Walks the tensor over one word-addressed request port, counting saturation events.
module conv_weight_update #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] g_base,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] lr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  sat_count
);

  typedef enum logic [2:0] {StWait, StRdG, StRdW, StEx, StWb, StDone} state_e;

  localparam logic signed [2*DATA_W-1:0] PMax = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] PMin = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DMin = {1'b1, {(DATA_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  w_base_q, w_base_d, g_base_q, g_base_d;
  logic [LEN_W-1:0]   len_q, len_d, index_q, index_d, sat_q, sat_d;
  logic [DATA_W-1:0]  lr_q, lr_d, g_q, g_d, w_q, w_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic signed [2*DATA_W-1:0] prod, p_sh;
  logic                       p_hi, p_lo, d_ovf;
  logic [DATA_W-1:0]          p_sat, d_val;
  logic [DATA_W:0]            d_wide;

  // Datapath for the EX step; operands are stable registers from the two reads.
  always_comb begin
    prod   = $signed(lr_q) * $signed(g_q);
    p_sh   = prod >>> FRAC;
    p_hi   = p_sh > PMax;
    p_lo   = p_sh < PMin;
    p_sat  = p_hi ? DMax : (p_lo ? DMin : p_sh[DATA_W-1:0]);
    d_wide = {w_q[DATA_W-1], w_q} - {p_sat[DATA_W-1], p_sat};
    d_ovf  = d_wide[DATA_W] ^ d_wide[DATA_W-1];
    d_val  = d_ovf ? (d_wide[DATA_W] ? DMin : DMax) : d_wide[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    w_base_d    = w_base_q;
    g_base_d    = g_base_q;
    len_d       = len_q;
    lr_d        = lr_q;
    index_d     = index_q;
    sat_d       = sat_q;
    g_d         = g_q;
    w_d         = w_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StWait: begin
        if (go) begin
          w_base_d = w_base;
          g_base_d = g_base;
          len_d    = len;
          lr_d     = lr;
          index_d  = '0;
          sat_d    = '0;
          state_d  = (len == '0) ? StDone : StRdG;
        end
      end
      StRdG: begin
        if (mem_ack) begin
          g_d     = mem_rdata;
          state_d = StRdW;
        end
      end
      StRdW: begin
        if (mem_ack) begin
          w_d     = mem_rdata;
          state_d = StEx;
        end
      end
      StEx: begin
        mem_wdata_d = d_val;
        if ((p_hi || p_lo || d_ovf) && (sat_q != '1)) begin
          sat_d = sat_q + LEN_W'(1);
        end
        state_d = StWb;
      end
      StWb: begin
        if (mem_ack) begin
          if (index_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end else begin
            index_d = index_q + LEN_W'(1);
            state_d = StRdG;
          end
        end
      end
      StDone:  state_d = StWait;
      default: state_d = StWait;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mem_req_d = (state_d == StRdG) || (state_d == StRdW) || (state_d == StWb);
    mem_we_d  = (state_d == StWb);
    busy_d    = (state_d != StWait) && (state_d != StDone);
    done_d    = (state_d == StDone);
    unique case (state_d)
      StRdG:       mem_addr_d = g_base_d + ADDR_W'(index_d);
      StRdW, StWb: mem_addr_d = w_base_d + ADDR_W'(index_d);
      default:     mem_addr_d = mem_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StWait;
      w_base_q    <= '0;
      g_base_q    <= '0;
      len_q       <= '0;
      lr_q        <= '0;
      index_q     <= '0;
      sat_q       <= '0;
      g_q         <= '0;
      w_q         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_base_q    <= w_base_d;
      g_base_q    <= g_base_d;
      len_q       <= len_d;
      lr_q        <= lr_d;
      index_q     <= index_d;
      sat_q       <= sat_d;
      g_q         <= g_d;
      w_q         <= w_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_conv_weight_update.sv
// Directed bench for conv_weight_update: memory model with random ack stalls, SGD reference
// model with expected-write queue, and literal checks pinning the model.
module tb_conv_weight_update;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        go = 1'b0;
  logic [31:0] w_base = '0, g_base = '0, lr = '0;
  logic [15:0] len = '0;
  logic        mem_req, mem_we, mem_ack, busy, done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] sat_count;

  conv_weight_update dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .go        (go),
    .w_base    (w_base),
    .g_base    (g_base),
    .len       (len),
    .lr        (lr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int unsigned exp_sat = 0;
  int unsigned max_stall = 0;
  int unsigned stall_left = 0;
  int unsigned stall_cnt = 0;
  logic        hold_en = 1'b0;
  logic [31:0] hold_addr = '0;

  assign mem_ack   = mem_req && (stall_left == 0) && !(hold_en && mem_addr == hold_addr);
  assign mem_rdata = mem[mem_addr[9:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none/timely", name);
  endtask

  // Reference SGD step: returns {saturated, new_w}.
  function automatic logic [32:0] sgd(input logic [31:0] w, input logic [31:0] g,
                                      input logic [31:0] r);
    longint p;
    longint dd;
    logic   s;
    logic [31:0] res;
    s = 1'b0;
    p = (longint'($signed(r)) * longint'($signed(g))) >>> 16;
    if (p > 64'sd2147483647) begin p = 64'sd2147483647; s = 1'b1; end
    else if (p < -64'sd2147483648) begin p = -64'sd2147483648; s = 1'b1; end
    dd = longint'($signed(w)) - p;
    if (dd > 64'sd2147483647) begin dd = 64'sd2147483647; s = 1'b1; end
    else if (dd < -64'sd2147483648) begin dd = -64'sd2147483648; s = 1'b1; end
    res = dd[31:0];
    return {s, res};
  endfunction

  // Memory responder plus write scoreboard.
  always @(posedge clk) begin
    if (rst_l && mem_req && mem_ack) begin
      stall_left <= $urandom_range(max_stall, 0);
      if (mem_we) begin
        mem[mem_addr[9:0]] = mem_wdata;
        if (exp_addr_q.size() == 0) fail("unexpected_write");
        else begin
          check("wr_addr", mem_addr, exp_addr_q.pop_front());
          check("wr_data", mem_wdata, exp_data_q.pop_front());
        end
      end
    end else if (rst_l && mem_req) begin
      stall_cnt <= stall_cnt + 1;
      if (stall_left != 0) stall_left <= stall_left - 1;
    end
  end

  // Request must hold steady while stalled.
  logic        stalled = 1'b0;
  logic        s_we;
  logic [31:0] s_addr, s_data;
  always @(posedge clk) begin
    stalled <= rst_l && mem_req && !mem_ack;
    s_addr  <= mem_addr;
    s_data  <= mem_wdata;
    s_we    <= mem_we;
  end
  always @(negedge clk) begin
    if (stalled && rst_l) begin
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, s_addr);
      check("stall_we", mem_we, s_we);
      if (s_we) check("stall_wdata", mem_wdata, s_data);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[9:0]]     = v;
    ref_mem[a[9:0]] = v;
  endtask

  task automatic plan(input logic [31:0] wb, input logic [31:0] gb, input int n,
                      input logic [31:0] r);
    logic [31:0] ga, wa;
    logic [32:0] res;
    exp_sat = 0;
    for (int i = 0; i < n; i++) begin
      ga  = gb + i;
      wa  = wb + i;
      res = sgd(ref_mem[wa[9:0]], ref_mem[ga[9:0]], r);
      ref_mem[wa[9:0]] = res[31:0];
      exp_addr_q.push_back(wa);
      exp_data_q.push_back(res[31:0]);
      if (res[32] && exp_sat != 16'hFFFF) exp_sat++;
    end
  endtask

  task automatic start_go(input logic [31:0] wb, input logic [31:0] gb, input int n,
                          input logic [31:0] r);
    @(posedge clk);
    #1;
    w_base = wb;
    g_base = gb;
    len    = 16'(n);
    lr     = r;
    go     = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] wb, input logic [31:0] gb, input int n,
                         input logic [31:0] r, input bit inject,
                         output int cyc, output bit saw_req);
    int unsigned stall0;
    bit injected;
    injected = 1'b0;
    plan(wb, gb, n, r);
    start_go(wb, gb, n, r);
    stall0  = stall_cnt;
    cyc     = 0;
    saw_req = mem_req;
    while (!done && cyc < 40 * n + 20) begin
      if (inject && !injected && mem_req && mem_we) begin
        w_base = 32'h3F0;
        g_base = 32'h3E0;
        len    = 16'd7;
        go     = 1'b1;
        injected = 1'b1;
      end
      @(posedge clk);
      #1;
      go = 1'b0;
      cyc++;
      saw_req |= mem_req;
    end
    if (!done) fail("done_timeout");
    check("latency", cyc, 4 * n + (stall_cnt - stall0));
    check("sat_count", sat_count, exp_sat);
    check("busy_at_done", busy, 0);
    check("pending_writes", exp_addr_q.size(), 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  saw;
    logic [31:0] tbl [4];
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_count, 0);
    rst_l = 1'b1;

    // Pin the model with hand-computed values
    check("model_basic", sgd(32'h0003_0000, 32'h0002_0000, 32'h0000_8000), {1'b0, 32'h0002_0000});
    check("model_dsat", sgd(32'h8000_0001, 32'h0001_0000, 32'h0001_0000), {1'b1, 32'h8000_0000});
    check("model_psat", sgd(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), {1'b1, 32'h0000_0000});
    check("model_floor", sgd(32'h0000_0005, 32'h0000_0001, 32'hFFFF_8000), {1'b0, 32'h0000_0006});

    // Basic step
    preload(32'h10, 32'h0002_0000);
    preload(32'h20, 32'h0003_0000);
    run_job(32'h20, 32'h10, 1, 32'h0000_8000, 1'b0, cyc, saw);
    check("basic_latency", cyc, 4);
    check("basic_mem", mem[32'h20], 32'h0002_0000);
    check("basic_sat", sat_count, 0);

    // Vector with stalls
    max_stall = 3;
    for (int i = 0; i < 4; i++) begin
      preload(32'h100 + i, (i + 1) << 16);
      preload(32'h200 + i, 32'h000A_0000);
    end
    run_job(32'h200, 32'h100, 4, 32'h0001_0000, 1'b0, cyc, saw);
    tbl[0] = 32'h0009_0000; tbl[1] = 32'h0008_0000;
    tbl[2] = 32'h0007_0000; tbl[3] = 32'h0006_0000;
    for (int i = 0; i < 4; i++) check("stall_mem", mem[32'h200 + i], tbl[i]);
    max_stall = 0;

    // Saturation on the subtraction
    preload(32'h30, 32'h0001_0000);
    preload(32'h40, 32'h8000_0001);
    run_job(32'h40, 32'h30, 1, 32'h0001_0000, 1'b0, cyc, saw);
    check("dsat_mem", mem[32'h40], 32'h8000_0000);
    check("dsat_count", sat_count, 1);

    // Saturation on the product
    preload(32'h31, 32'h7FFF_FFFF);
    preload(32'h41, 32'h7FFF_FFFF);
    run_job(32'h41, 32'h31, 1, 32'h7FFF_FFFF, 1'b0, cyc, saw);
    check("psat_mem", mem[32'h41], 32'h0000_0000);
    check("psat_count", sat_count, 1);

    // len == 0
    run_job(32'h20, 32'h10, 0, 32'h0001_0000, 1'b0, cyc, saw);
    check("len0_latency", cyc, 0);
    check("len0_no_req", saw, 0);

    // go ignored while busy
    preload(32'h50, 32'h0001_0000);
    preload(32'h51, 32'h0002_0000);
    preload(32'h58, 32'h0005_0000);
    preload(32'h59, 32'h0005_0000);
    run_job(32'h58, 32'h50, 2, 32'h0001_0000, 1'b1, cyc, saw);
    check("ign_mem0", mem[32'h58], 32'h0004_0000);
    check("ign_mem1", mem[32'h59], 32'h0003_0000);
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      saw |= mem_req | busy;
    end
    check("ign_no_second_job", saw, 0);

    // Aliasing and negative learning rate with floor rounding
    preload(32'h300, 32'h0004_0000);
    preload(32'h301, 32'h0001_0000);
    max_stall = 2;
    run_job(32'h300, 32'h300, 2, 32'h0000_8000, 1'b0, cyc, saw);
    check("alias_mem0", mem[32'h300], 32'h0002_0000);
    check("alias_mem1", mem[32'h301], 32'h0000_8000);
    max_stall = 0;
    preload(32'h60, 32'h0000_0001);
    preload(32'h61, 32'h0002_0000);
    preload(32'h68, 32'h0000_0005);
    preload(32'h69, 32'h0001_0000);
    run_job(32'h68, 32'h60, 2, 32'hFFFF_8000, 1'b0, cyc, saw);
    check("neg_mem0", mem[32'h68], 32'h0000_0006);
    check("neg_mem1", mem[32'h69], 32'h0002_0000);

    // Reset mid-job while stalled in the weight read
    preload(32'h70, 32'h0001_0000);
    preload(32'h71, 32'h0001_0000);
    preload(32'h78, 32'h0003_0000);
    preload(32'h79, 32'h0003_0000);
    hold_en   = 1'b1;
    hold_addr = 32'h78;
    plan(32'h78, 32'h70, 2, 32'h0001_0000);
    start_go(32'h78, 32'h70, 2, 32'h0001_0000);
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h78) && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 20) fail("rdw_timeout");
    #2;
    rst_l = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    ref_mem[10'h78] = mem[32'h78];
    ref_mem[10'h79] = mem[32'h79];
    check("abort_mem_kept", mem[32'h78], 32'h0003_0000);
    hold_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", {mem_req, busy, done}, 3'b000);
    run_job(32'h78, 32'h70, 2, 32'h0001_0000, 1'b0, cyc, saw);
    check("post_rst_mem0", mem[32'h78], 32'h0002_0000);
    check("post_rst_mem1", mem[32'h79], 32'h0002_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
